// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand request / product result bus for the shift-add multiplier
interface shift_add_multiplier_if #(parameter int WIDTH = 8);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier, one multiplier bit per clock, registered outputs
module shift_add_multiplier #(parameter int WIDTH = 8) (
    input logic                   clk,
    input logic                   reset,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] product_q;
    logic               busy_q, done_q;
    logic [WIDTH:0]     upper;
    // acc_q[2W] is the carry slot; it is always zero on entry so it can join the upper-half add
    always_comb begin
        upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d = {1'b0, upper, acc_q[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    mcand_q <= bus.a;
                    acc_q   <= {{(WIDTH+1){1'b0}}, bus.b};
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        product_q <= acc_d[2*WIDTH-1:0];
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: WIDTH=8 and WIDTH=4 multipliers checked every cycle against a timing/arithmetic model
module tb_shift_add_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    shift_add_multiplier_if #(.WIDTH(8)) bus8 ();
    shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
    shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    localparam int WID [2] = '{8, 4};
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int acc_at [2];
    int ea [2];
    int eb [2];
    int exp_prod [2];
    int n_acc [2] = '{0, 0};
    bit act [2];
    bit nxt_idle [2];
    bit exp_busy [2];
    bit exp_done [2];
    bit pin_en = 1'b0;
    int pin_exp = 0;
    int base;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h cycle=%0d", nm, got, exp, cyc);
    endtask

    // Model: an op accepted at edge N is busy through edge N+W, done at edge N+W, next accept at N+W+2
    always @(posedge clk) begin
        int e;
        bit s;
        int av, bv;
        e = cyc;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            s  = (i == 0) ? bus8.start : bus4.start;
            av = (i == 0) ? int'(bus8.a) : int'(bus4.a);
            bv = (i == 0) ? int'(bus8.b) : int'(bus4.b);
            if (reset) begin
                act[i] = 1'b0;
                exp_prod[i] = 0;
            end else begin
                if (act[i] && e >= acc_at[i] + WID[i] + 2) act[i] = 1'b0;
                if (!act[i] && s) begin
                    act[i] = 1'b1;
                    acc_at[i] = e;
                    ea[i] = av;
                    eb[i] = bv;
                    n_acc[i]++;
                end
                if (act[i] && e == acc_at[i] + WID[i]) exp_prod[i] = ea[i] * eb[i];
            end
            exp_busy[i] = act[i] && e <= acc_at[i] + WID[i];
            exp_done[i] = act[i] && e == acc_at[i] + WID[i];
            nxt_idle[i] = !act[i] || e + 1 >= acc_at[i] + WID[i] + 2;
        end
    end

    always @(negedge clk) begin
        check("busy8", 32'(bus8.busy), 32'(exp_busy[0]));
        check("done8", 32'(bus8.done), 32'(exp_done[0]));
        check("product8", 32'(bus8.product), 32'(exp_prod[0]));
        check("busy4", 32'(bus4.busy), 32'(exp_busy[1]));
        check("done4", 32'(bus4.done), 32'(exp_done[1]));
        check("product4", 32'(bus4.product), 32'(exp_prod[1]));
        if (pin_en && exp_done[0]) begin
            check("pin_product", 32'(exp_prod[0]), 32'(pin_exp));
            check("pin_latency", 32'(cyc - 1 - acc_at[0]), 32'd8);
        end
    end

    task automatic op8(input int av, input int bv, input int pe);
        while (!nxt_idle[0]) @(negedge clk);
        pin_en = 1'b1;
        pin_exp = pe;
        bus8.start = 1'b1;
        bus8.a = 8'(av);
        bus8.b = 8'(bv);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        while (!nxt_idle[0]) @(negedge clk);
    endtask

    initial begin
        bus4.start = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        forever begin
            @(negedge clk);
            bus4.start = 1'($urandom_range(0, 1));
            bus4.a = 4'($urandom);
            bus4.b = 4'($urandom);
        end
    end

    initial begin
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        op8(3, 5, 'h000F);
        op8('hFF, 'hFF, 'hFE01);
        op8('h80, 'h02, 'h0100);
        op8(0, 'hAB, 0);
        op8('hAB, 0, 0);
        pin_exp = 'h0078;
        bus8.start = 1'b1;
        bus8.a = 8'd12;
        bus8.b = 8'd10;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = 8'd7;
        bus8.b = 8'd7;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'h55;
        bus8.b = 8'hAA;
        while (!nxt_idle[0]) @(negedge clk);
        pin_en = 1'b0;
        bus8.start = 1'b1;
        bus8.a = 8'd9;
        bus8.b = 8'd9;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op8(2, 3, 6);
        pin_en = 1'b1;
        pin_exp = 'h002A;
        bus8.start = 1'b1;
        bus8.a = 8'd6;
        bus8.b = 8'd7;
        repeat (35) @(negedge clk);
        bus8.start = 1'b0;
        while (!nxt_idle[0]) @(negedge clk);
        pin_en = 1'b0;
        base = n_acc[0];
        while (n_acc[0] < base + 500) begin
            @(negedge clk);
            bus8.start = 1'($urandom_range(0, 1));
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
        end
        bus8.start = 1'b0;
        while (n_acc[1] < 500 || !nxt_idle[0]) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
